// File: rtl/eq_gain_regfile_if.sv
// Byte-wide control bus between the control-bus decoder (master)
// and the equaliser gain register file (slave).
interface eq_gain_regfile_if;
    logic       we;
    logic       re;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rvalid;
    logic       err;

    modport master (
        output we, re, addr, wdata,
        input  rdata, rvalid, err
    );

    modport slave (
        input  we, re, addr, wdata,
        output rdata, rvalid, err
    );
endinterface

// File: rtl/eq_gain_regfile.sv
// Equaliser gain register file: byte-wise shadow gains, commit on a
// sample boundary, then a linear per-sample ramp of the active gains
// toward their targets.
module eq_gain_regfile #(
    parameter int NUM_BANDS  = 10,
    parameter int GAIN_WIDTH = 13,
    parameter int FRAC_BITS  = 8,
    parameter int RAMP_STEP  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    eq_gain_regfile_if.slave                bus,
    input  logic                            sample_tick,
    output logic [NUM_BANDS*GAIN_WIDTH-1:0] gain_out,
    output logic                            ramp_busy
);

    localparam int IDX_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam logic [GAIN_WIDTH-1:0] UNITY      = GAIN_WIDTH'(1) << FRAC_BITS;
    localparam logic [GAIN_WIDTH:0]   STEP_EXT   = (GAIN_WIDTH+1)'(RAMP_STEP);
    localparam logic [8:0]            BAND_LIMIT = 9'(2 * NUM_BANDS);
    localparam logic [7:0]            ADDR_CTRL   = 8'hF0;
    localparam logic [7:0]            ADDR_STATUS = 8'hF1;

    logic [GAIN_WIDTH-1:0] shadow_q [NUM_BANDS];
    logic [GAIN_WIDTH-1:0] shadow_d [NUM_BANDS];
    logic [GAIN_WIDTH-1:0] target_q [NUM_BANDS];
    logic [GAIN_WIDTH-1:0] target_d [NUM_BANDS];
    logic [GAIN_WIDTH-1:0] active_q [NUM_BANDS];
    logic [GAIN_WIDTH-1:0] active_d [NUM_BANDS];

    logic [7:0] hold_q, hold_d;
    logic       pending_q, pending_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rvalid_q, rvalid_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;

    logic                  band_hit;
    logic [IDX_W-1:0]      band_idx;
    logic [GAIN_WIDTH-1:0] rd_word;

    // One ramp step: move by RAMP_STEP toward the target, landing exactly
    // on it when the remaining distance is within one step. The extra bit
    // keeps the difference free of wrap in either direction.
    function automatic logic [GAIN_WIDTH-1:0] ramp_next(
        input logic [GAIN_WIDTH-1:0] act,
        input logic [GAIN_WIDTH-1:0] tgt
    );
        logic [GAIN_WIDTH:0] a_ext;
        logic [GAIN_WIDTH:0] t_ext;
        logic [GAIN_WIDTH:0] diff;
        a_ext = {1'b0, act};
        t_ext = {1'b0, tgt};
        if (t_ext >= a_ext) begin
            diff = t_ext - a_ext;
            if (32'(diff) <= RAMP_STEP) ramp_next = tgt;
            else                        ramp_next = GAIN_WIDTH'(a_ext + STEP_EXT);
        end else begin
            diff = a_ext - t_ext;
            if (32'(diff) <= RAMP_STEP) ramp_next = tgt;
            else                        ramp_next = GAIN_WIDTH'(a_ext - STEP_EXT);
        end
        return ramp_next;
    endfunction

    // Address decode for the band register window
    always_comb begin
        band_hit = ({1'b0, bus.addr} < BAND_LIMIT);
        band_idx = IDX_W'(bus.addr[7:1]);
        rd_word  = band_hit ? shadow_q[band_idx] : '0;
    end

    // Next-state logic: bus access, commit transfer, ramp and busy flag
    always_comb begin
        shadow_d  = shadow_q;
        target_d  = target_q;
        active_d  = active_q;
        hold_d    = hold_q;
        pending_d = pending_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        err_d     = 1'b0;
        busy_d    = 1'b0;

        // Ramp uses the pre-tick target, so a fresh target starts moving
        // one tick after it is loaded.
        if (sample_tick) begin
            for (int k = 0; k < NUM_BANDS; k++) begin
                active_d[k] = ramp_next(active_q[k], target_q[k]);
            end
            if (pending_q) begin
                for (int k = 0; k < NUM_BANDS; k++) begin
                    target_d[k] = shadow_q[k];
                end
                pending_d = 1'b0;
            end
        end

        // A write wins over a simultaneous read; the read is dropped.
        if (bus.we) begin
            if (band_hit) begin
                if (!bus.addr[0]) begin
                    hold_d = bus.wdata;
                end else begin
                    shadow_d[band_idx] = {bus.wdata[GAIN_WIDTH-9:0], hold_q};
                end
            end else if (bus.addr == ADDR_CTRL) begin
                if (bus.wdata[0]) pending_d = 1'b1;
            end else if (bus.addr != ADDR_STATUS) begin
                err_d = 1'b1;
            end
        end else if (bus.re) begin
            rvalid_d = 1'b1;
            if (band_hit) begin
                rdata_d = bus.addr[0] ? 8'(rd_word >> 8) : rd_word[7:0];
            end else if (bus.addr == ADDR_STATUS) begin
                rdata_d = {6'b0, pending_q, busy_q};
            end else if (bus.addr == ADDR_CTRL) begin
                rdata_d = 8'h00;
            end else begin
                rdata_d = 8'h00;
                err_d   = 1'b1;
            end
        end

        for (int k = 0; k < NUM_BANDS; k++) begin
            if (active_d[k] != target_d[k]) busy_d = 1'b1;
        end
    end

    // State registers with asynchronous return to unity gain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_BANDS; k++) begin
                shadow_q[k] <= UNITY;
                target_q[k] <= UNITY;
                active_q[k] <= UNITY;
            end
            hold_q    <= 8'h00;
            pending_q <= 1'b0;
            rdata_q   <= 8'h00;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            target_q  <= target_d;
            active_q  <= active_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;
    assign ramp_busy  = busy_q;

    generate
        for (genvar gi = 0; gi < NUM_BANDS; gi++) begin : g_gain_out
            assign gain_out[gi*GAIN_WIDTH +: GAIN_WIDTH] = active_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_eq_gain_regfile.sv
// Directed bench for eq_gain_regfile with default parameters
// (10 bands, 13-bit gains, 8 fractional bits, step 16).
module tb_eq_gain_regfile;

    localparam int NB = 10;
    localparam int GW = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sample_tick = 1'b0;
    logic [NB*GW-1:0] gain_out;
    logic ramp_busy;

    int checks = 0;
    int errors = 0;

    eq_gain_regfile_if bus_if ();

    eq_gain_regfile #(
        .NUM_BANDS (NB),
        .GAIN_WIDTH(GW),
        .FRAC_BITS (8),
        .RAMP_STEP (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .sample_tick(sample_tick),
        .gain_out   (gain_out),
        .ramp_busy  (ramp_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    function automatic logic [31:0] band(input int k);
        return 32'(gain_out[k*GW +: GW]);
    endfunction

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        bus_if.we = 1'b1;
        bus_if.addr = a;
        bus_if.wdata = d;
        @(posedge clk); #1;
        bus_if.we = 1'b0;
    endtask

    task automatic read_expect(input string tag, input logic [7:0] a, input logic [7:0] exp);
        bus_if.re = 1'b1;
        bus_if.addr = a;
        @(posedge clk); #1;
        bus_if.re = 1'b0;
        check({tag, " rvalid"}, 32'(bus_if.rvalid), 32'd1);
        check({tag, " rdata"}, 32'(bus_if.rdata), 32'(exp));
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
    endtask

    initial begin
        bus_if.we = 1'b0;
        bus_if.re = 1'b0;
        bus_if.addr = 8'h00;
        bus_if.wdata = 8'h00;

        // Reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst band0", band(0), 32'h100);
        check("rst band2", band(2), 32'h100);
        check("rst band9", band(9), 32'h100);
        check("rst rdata", 32'(bus_if.rdata), 32'h00);
        check("rst rvalid", 32'(bus_if.rvalid), 32'd0);
        check("rst err", 32'(bus_if.err), 32'd0);
        check("rst busy", 32'(ramp_busy), 32'd0);
        read_expect("rst status", 8'hF1, 8'h00);

        // Shadow write and readback
        bus_write(8'h04, 8'h00);
        bus_write(8'h05, 8'h02);
        check("wr err", 32'(bus_if.err), 32'd0);
        read_expect("rd 0x05", 8'h05, 8'h02);
        read_expect("rd 0x04", 8'h04, 8'h00);
        @(posedge clk); #1;
        check("rvalid drop", 32'(bus_if.rvalid), 32'd0);
        check("band2 pre-commit", band(2), 32'h100);

        // Commit and ramp up
        bus_write(8'hF0, 8'h01);
        read_expect("status pending", 8'hF1, 8'h02);
        read_expect("ctrl read", 8'hF0, 8'h00);
        check("ctrl read err", 32'(bus_if.err), 32'd0);
        tick();
        check("xfer band2", band(2), 32'h100);
        check("xfer busy", 32'(ramp_busy), 32'd1);
        read_expect("status ramping", 8'hF1, 8'h01);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("ramp%0d band2", i), band(2), 32'(32'h100 + 16 * i));
            check($sformatf("ramp%0d busy", i), 32'(ramp_busy), (i < 16) ? 32'd1 : 32'd0);
        end

        // Ramp clamping: small up-step then down-step
        bus_write(8'h00, 8'h05);
        bus_write(8'h01, 8'h01);
        bus_write(8'hF0, 8'h01);
        tick();
        check("clamp up xfer busy", 32'(ramp_busy), 32'd1);
        tick();
        check("clamp up band0", band(0), 32'h105);
        check("clamp up busy", 32'(ramp_busy), 32'd0);
        bus_write(8'h00, 8'hF0);
        bus_write(8'h01, 8'h00);
        bus_write(8'hF0, 8'h01);
        tick();
        tick();
        check("clamp dn1 band0", band(0), 32'h0F5);
        tick();
        check("clamp dn2 band0", band(0), 32'h0F0);
        tick();
        check("clamp hold band0", band(0), 32'h0F0);

        // Error cases (hold currently 0xF0)
        bus_write(8'h14, 8'h55);
        check("unmapped wr err", 32'(bus_if.err), 32'd1);
        @(posedge clk); #1;
        check("err one cycle", 32'(bus_if.err), 32'd0);
        bus_write(8'h03, 8'h00);
        read_expect("hold untouched", 8'h02, 8'hF0);
        read_expect("unmapped rd", 8'h30, 8'h00);
        check("unmapped rd err", 32'(bus_if.err), 32'd1);
        bus_write(8'h01, 8'hFF);
        read_expect("msb trunc", 8'h01, 8'h1F);
        read_expect("lsb after trunc", 8'h00, 8'hF0);
        bus_if.we = 1'b1;
        bus_if.re = 1'b1;
        bus_if.addr = 8'h07;
        bus_if.wdata = 8'h03;
        @(posedge clk); #1;
        bus_if.we = 1'b0;
        bus_if.re = 1'b0;
        check("we+re rvalid", 32'(bus_if.rvalid), 32'd0);
        read_expect("we+re written", 8'h07, 8'h03);
        read_expect("top band msb", 8'h13, 8'h01);
        check("top band err", 32'(bus_if.err), 32'd0);
        bus_write(8'hF1, 8'hFF);
        check("status wr err", 32'(bus_if.err), 32'd0);
        read_expect("status after wr", 8'hF1, 8'h00);

        // Reset mid-ramp with a commit pending
        bus_write(8'hF0, 8'h01);
        tick();
        repeat (5) tick();
        check("mid band0", band(0), 32'h140);
        check("mid band3", band(3), 32'h150);
        check("mid busy", 32'(ramp_busy), 32'd1);
        bus_write(8'hF0, 8'h01);
        read_expect("pre-rst msb", 8'h01, 8'h1F);
        #2 rst = 1'b1;
        #1;
        check("async band0", band(0), 32'h100);
        check("async band3", band(3), 32'h100);
        check("async busy", 32'(ramp_busy), 32'd0);
        check("async rdata", 32'(bus_if.rdata), 32'h00);
        @(posedge clk); #1 rst = 1'b0;
        read_expect("post-rst status", 8'hF1, 8'h00);
        read_expect("post-rst shadow0", 8'h01, 8'h01);
        tick();
        check("no ramp back band3", band(3), 32'h100);
        check("no ramp back busy", 32'(ramp_busy), 32'd0);

        // Commit written in a tick cycle
        bus_write(8'h04, 8'h80);
        bus_write(8'h05, 8'h01);
        bus_if.we = 1'b1;
        bus_if.addr = 8'hF0;
        bus_if.wdata = 8'h01;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        bus_if.we = 1'b0;
        sample_tick = 1'b0;
        check("tickcommit busy", 32'(ramp_busy), 32'd0);
        read_expect("tickcommit status", 8'hF1, 8'h02);
        tick();
        check("tickcommit xfer busy", 32'(ramp_busy), 32'd1);
        check("tickcommit xfer band2", band(2), 32'h100);
        tick();
        check("tickcommit step band2", band(2), 32'h110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
